spi_input_conditioner: RTL and testbench

SPI_INPUT_CONDITIONER -- requirements
Module: spi_input_conditioner

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_cond_channel.sv | 67 ++++++
 rtl/spi_input_conditioner.sv | 63 ++++++
 tb/tb_spi_input_conditioner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI pin conditioner.
// Idle levels double as the reset values of each channel.
package spi_pkg;

   localparam int WAIT_CYCLES_DEF = 3;
   localparam int CNT_W_DEF       = 3;

   localparam logic SCLK_IDLE = 1'b0;
   localparam logic CS_IDLE   = 1'b1;
   localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_cond_channel.sv
// One pin: two-flop synchronizer, stability counter,
// conditioned level and registered edge pulses.
module spi_cond_channel
   import spi_pkg::*;
#(
   parameter int   WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int   CNT_W       = CNT_W_DEF,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic cond_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_CYCLES);

   logic             sync0_q;
   logic             sync1_q;
   logic             cond_q, cond_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      cond_d = cond_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync1_q == cond_q) begin
         cnt_d = '0;
      end else if (cnt_q < WAIT_C) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         // Deviation held long enough: accept it and flag the edge
         cond_d = sync1_q;
         cnt_d  = '0;
         rise_d = sync1_q;
         fall_d = ~sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q <= RESET_VAL;
         sync1_q <= RESET_VAL;
         cond_q  <= RESET_VAL;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync0_q <= pin_i;
         sync1_q <= sync0_q;
         cond_q  <= cond_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign cond_o = cond_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_input_conditioner.sv
// Conditions the raw SPI pins (sclk, cs, mosi) into clean,
// clock-domain levels plus sclk/cs edge pulses.
module spi_input_conditioner
   import spi_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_pin,
   input  logic cs_pin,
   input  logic mosi_pin,
   output logic sclk_cond,
   output logic cs_cond,
   output logic mosi_cond,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise
);

   spi_cond_channel #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (SCLK_IDLE)
   ) u_sclk (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (sclk_pin),
      .cond_o (sclk_cond),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   spi_cond_channel #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (CS_IDLE)
   ) u_cs (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (cs_pin),
      .cond_o (cs_cond),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   // Data line needs only its level; edges are meaningless here
   spi_cond_channel #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (MOSI_IDLE)
   ) u_mosi (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (mosi_pin),
      .cond_o (mosi_cond),
      .rise_o (),
      .fall_o ()
   );

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner: segment table, timed corner
// sequences and random pin activity against a run-length model.
module tb_spi_input_conditioner;

   localparam int WAIT = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic sclk_pin, cs_pin, mosi_pin;
   logic sclk_cond, cs_cond, mosi_cond;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   spi_input_conditioner #(
      .WAIT_CYCLES (WAIT),
      .CNT_W       (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk_pin  (sclk_pin),
      .cs_pin    (cs_pin),
      .mosi_pin  (mosi_pin),
      .sclk_cond (sclk_cond),
      .cs_cond   (cs_cond),
      .mosi_cond (mosi_cond),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int n_sr, n_sf, n_cf, n_cr, n_both, collide;
   bit mosi_seen[$];
   bit edge_seq[$];

   typedef struct {
      logic sclk, cs, mosi;
      int   cyc;
      logic e_sclk, e_cs, e_mosi;
      int   e_sr, e_sf, e_cf, e_cr;
   } vec_t;

   vec_t tbl[9];

   // reference model: pins seen two edges late, run length of mismatches
   bit hist[3][$];
   bit mcond[3];
   int run[3];
   bit mrise[3];
   bit mfall[3];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic clr_mon();
      n_sr = 0; n_sf = 0; n_cf = 0; n_cr = 0;
      n_both = 0; collide = 0;
      mosi_seen = {};
      edge_seq = {};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (sclk_rise) begin
         n_sr++;
         mosi_seen.push_back(mosi_cond);
         edge_seq.push_back(1'b1);
      end
      if (sclk_fall) begin
         n_sf++;
         edge_seq.push_back(1'b0);
      end
      if (cs_fall) n_cf++;
      if (cs_rise) n_cr++;
      if (sclk_rise && cs_fall) n_both++;
      if ((sclk_rise && sclk_fall) || (cs_rise && cs_fall)) collide++;
   endtask

   task automatic pins(input logic s, input logic c, input logic m);
      sclk_pin = s;
      cs_pin   = c;
      mosi_pin = m;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pins(1'b0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < 3; ch++) begin
         hist[ch] = {};
         hist[ch].push_back(ch == 1);
         hist[ch].push_back(ch == 1);
         mcond[ch] = (ch == 1);
         run[ch]   = 0;
         mrise[ch] = 1'b0;
         mfall[ch] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit p[3];
      bit v;
      p[0] = sclk_pin;
      p[1] = cs_pin;
      p[2] = mosi_pin;
      for (int ch = 0; ch < 3; ch++) begin
         v = hist[ch].pop_front();
         hist[ch].push_back(p[ch]);
         mrise[ch] = 1'b0;
         mfall[ch] = 1'b0;
         if (v == mcond[ch]) begin
            run[ch] = 0;
         end else begin
            run[ch]++;
            if (run[ch] == WAIT + 1) begin
               mcond[ch] = v;
               mrise[ch] = v;
               mfall[ch] = !v;
               run[ch]   = 0;
            end
         end
      end
   endtask

   initial begin
      bit [7:0] pat;
      logic [6:0] act, exp;

      tbl[0] = '{1'b0, 1'b1, 1'b0, 20, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b0,  3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
      tbl[3] = '{1'b1, 1'b1, 1'b0,  5, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 12, 1'b0, 1'b1, 1'b0, 1, 1, 0, 0};
      tbl[5] = '{1'b0, 1'b0, 1'b0,  4, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
      tbl[6] = '{1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b1, 1'b1, 1, 0, 0, 1};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b0, 0, 1, 1, 0};

      // reset state, checked while reset is held
      rst_n = 1'b0;
      pins(1'b1, 1'b0, 1'b1);
      #12;
      chk("reset_outputs",
          {sclk_cond, cs_cond, mosi_cond, sclk_rise, sclk_fall,
           cs_fall, cs_rise}, 7'b0100000);
      do_reset();

      for (int i = 0; i < 9; i++) begin
         clr_mon();
         pins(tbl[i].sclk, tbl[i].cs, tbl[i].mosi);
         repeat (tbl[i].cyc) tick();
         chk($sformatf("tbl%0d_cond", i), {sclk_cond, cs_cond, mosi_cond},
             {tbl[i].e_sclk, tbl[i].e_cs, tbl[i].e_mosi});
         chk($sformatf("tbl%0d_pulses", i), {n_sr, n_sf, n_cf, n_cr},
             {tbl[i].e_sr, tbl[i].e_sf, tbl[i].e_cf, tbl[i].e_cr});
         chk($sformatf("tbl%0d_collide", i), collide, 0);
      end

      pins(1'b0, 1'b1, 1'b0);
      repeat (12) tick();

      // cs fall latency: capture edge k, change after edge k+5
      clr_mon();
      pins(1'b0, 1'b0, 1'b0);
      for (int t = 1; t <= 5; t++) begin
         tick();
         chk($sformatf("cs_lat_hold%0d", t), {cs_cond, cs_fall}, 2'b10);
      end
      tick();
      chk("cs_lat_change", {cs_cond, cs_fall}, 2'b01);
      tick();
      chk("cs_lat_pulse_end", {cs_cond, cs_fall}, 2'b00);
      repeat (4) tick();
      chk("cs_lat_counts", {n_cf, n_cr}, {32'd1, 32'd0});
      pins(1'b0, 1'b1, 1'b0);
      repeat (12) tick();

      // simultaneous cs/sclk change
      clr_mon();
      pins(1'b1, 1'b0, 1'b0);
      repeat (6) tick();
      chk("simul_pulse", {sclk_rise, cs_fall}, 2'b11);
      repeat (8) tick();
      chk("simul_count", n_both, 1);
      pins(1'b0, 1'b1, 1'b0);
      repeat (12) tick();

      // SPI-like burst carrying 0xA5 MSB first
      clr_mon();
      pat = 8'hA5;
      for (int b = 7; b >= 0; b--) begin
         pins(1'b0, 1'b1, pat[b]);
         repeat (8) tick();
         pins(1'b1, 1'b1, pat[b]);
         repeat (8) tick();
      end
      pins(1'b0, 1'b1, 1'b0);
      repeat (12) tick();
      chk("burst_counts", {n_sr, n_sf}, {32'd8, 32'd8});
      chk("burst_collide", collide, 0);
      chk("burst_edges", edge_seq.size(), 16);
      for (int i = 0; i < edge_seq.size(); i++)
         chk($sformatf("burst_order%0d", i), edge_seq[i], (i % 2 == 0));
      chk("burst_bits", mosi_seen.size(), 8);
      for (int i = 0; i < mosi_seen.size() && i < 8; i++)
         chk($sformatf("burst_bit%0d", i), mosi_seen[i], pat[7-i]);

      // reset in the middle of a cs count, released with cs low
      clr_mon();
      pins(1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_async",
          {sclk_cond, cs_cond, mosi_cond, sclk_rise, sclk_fall,
           cs_fall, cs_rise}, 7'b0100000);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_held", {cs_cond, cs_fall}, 2'b10);
      #2 rst_n = 1'b1;
      clr_mon();
      tick();
      chk("rst_release_cycle",
          {cs_cond, cs_fall, cs_rise, sclk_rise, sclk_fall}, 5'b10000);
      for (int t = 2; t <= 5; t++) begin
         tick();
         chk($sformatf("rst_rel_hold%0d", t), {cs_cond, cs_fall}, 2'b10);
      end
      tick();
      chk("rst_rel_fall", {cs_cond, cs_fall}, 2'b01);
      repeat (6) tick();
      chk("rst_rel_counts", {n_cf, n_cr}, {32'd1, 32'd0});

      // random pin activity against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 4) == 0) sclk_pin = ~sclk_pin;
         if ($urandom_range(0, 5) == 0) cs_pin   = ~cs_pin;
         if ($urandom_range(0, 3) == 0) mosi_pin = ~mosi_pin;
         @(posedge clk);
         model_edge();
         #1;
         act = {sclk_cond, cs_cond, mosi_cond, sclk_rise, sclk_fall,
                cs_fall, cs_rise};
         exp = {mcond[0], mcond[1], mcond[2], mrise[0], mfall[0],
                mfall[1], mrise[1]};
         chk($sformatf("rand%0d", c), act, exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
